switch_debounce: RTL and testbench
==================================

// Module: switch_debounce
// PURPOSE
//   Conditions raw board switch/button inputs into clean, debounced logic levels plus
//   single-cycle rise/fall pulses for downstream combinational logic (e.g. OR/AND test
//   logic driving LEDs). Sits between the FPGA input pins and all user logic.
//   Each channel is an independent synchroniser, stability counter and state machine.
// PARAMETERS
//   N_CH          2      number of independent input channels
//   CNT_W         16     width of per-channel stability counter
//   STABLE_CYC    50000  cycles a new level must persist before acceptance (1 ms @ 50 MHz); 1..2^CNT_W-1
// PORTS
//   clk         in   1     system clock; all logic rising-edge
//   rst         in   1     synchronous, active-high reset
//   raw_in      in   N_CH  asynchronous raw pin levels
//   level_out   out  N_CH  debounced level per channel
//   rise_pulse  out  N_CH  1-cycle pulse when level_out goes 0->1
//   fall_pulse  out  N_CH  1-cycle pulse when level_out goes 1->0
//   press_cnt   out  8*N_CH  per-channel rise count (only with SWITCH_DEBOUNCE_CNT_EN)
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): level_out=0, rise/fall_pulse=0, counters=0, sync FFs=0,
//     state=S_LOW, press_cnt=0. Reset mid-wait discards the pending transition.
//   - Synchroniser: 2 flops per channel; sync_in = raw_in delayed 2 cycles.
//   - States per channel: S_LOW, S_WAIT_HI, S_HIGH, S_WAIT_LO.
//     S_LOW:     sync_in=1 -> S_WAIT_HI, cnt<=1.
//     S_WAIT_HI: sync_in=0 -> S_LOW, cnt<=0 (glitch rejected, no pulse).
//                sync_in=1 & cnt==STABLE_CYC-1 -> S_HIGH, level_out<=1, rise_pulse<=1.
//                else cnt<=cnt+1.
//     S_HIGH / S_WAIT_LO: mirror image; acceptance sets level_out<=0, fall_pulse<=1.
//   - Latency: raw edge held stable -> level_out change after exactly 2+STABLE_CYC cycles.
//   - Pulses are registered, high exactly one cycle, never both in the same cycle.
//   - Counter never wraps: it is cleared on every rejection/acceptance and bounded by
//     STABLE_CYC-1 < 2^CNT_W. STABLE_CYC=1 accepts on first sampled cycle of a new level.
//   - Bounce arriving exactly on the acceptance cycle: acceptance wins only if sync_in
//     still equals the target level on that edge; otherwise rejected.
//   - Channels fully independent; simultaneous events on several channels all honoured.
// CONFIGURATION
//   SWITCH_DEBOUNCE_CNT_EN defined: press_cnt port present; per channel 8-bit counter
//     increments on each rise_pulse, wraps 255->0, cleared by rst.
//   Not defined: press_cnt port and counters absent; all other behaviour identical.
// STRUCTURE
//   - Shared package switch_debounce_pkg: state encoding constants
//     (S_LOW=2'd0, S_WAIT_HI=2'd1, S_HIGH=2'd2, S_WAIT_LO=2'd3), default STABLE_CYC.
//   - Sub-module debounce_chan: one synchroniser + counter + FSM (+ optional press
//     counter); top instantiates N_CH copies via generate loop.
// TESTING (bench uses STABLE_CYC=8, N_CH=2)
//   1 rst held 3 cycles with raw_in=2'b11 -> all outputs 0, state S_LOW throughout.
//   2 raw_in[0] 0->1 held -> level_out[0]=1 exactly 10 cycles after edge, rise_pulse[0]
//     high 1 cycle, fall_pulse=0, channel 1 unchanged.
//   3 raw_in[0] 1 for 5 cycles then 0 (bounce) -> level_out[0] stays 0, no pulses.
//   4 both channels toggle same cycle, held 12 cycles -> both level_out bits change same
//     cycle, both rise_pulse bits high same single cycle.
//   5 rst asserted 4 cycles into a pending rise -> after reset, level_out=0, no pulse;
//     new stable high then takes full 10 cycles.
//   6 with SWITCH_DEBOUNCE_CNT_EN: 257 clean presses on channel 1 -> press_cnt[15:8]=1.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
// ============================================================================
// Module  : switch_debounce_pkg
// Brief   : Shared state encoding and default parameters for switch_debounce.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package switch_debounce_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] S_LOW     = 2'd0;
    localparam logic [STATE_W-1:0] S_WAIT_HI = 2'd1;
    localparam logic [STATE_W-1:0] S_HIGH    = 2'd2;
    localparam logic [STATE_W-1:0] S_WAIT_LO = 2'd3;

    localparam int DEFAULT_N_CH       = 2;
    localparam int DEFAULT_CNT_W      = 16;
    localparam int DEFAULT_STABLE_CYC = 50000;

endpackage

`default_nettype wire

// File: rtl/switch_debounce_chan.sv
// ============================================================================
// Module  : debounce_chan
// Brief   : One channel: 2-flop synchroniser, stability counter, 4-state FSM,
//           optional press counter (SWITCH_DEBOUNCE_CNT_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module debounce_chan
    import switch_debounce_pkg::*;
#(
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int STABLE_CYC = DEFAULT_STABLE_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_raw,
    output logic       o_level,
    output logic       o_rise,
    output logic       o_fall
`ifdef SWITCH_DEBOUNCE_CNT_EN
    ,
    output logic [7:0] o_press_cnt
`endif
);

    localparam logic [CNT_W-1:0] c_last      = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
    localparam logic             c_immediate = (STABLE_CYC == 1);

    logic               r_meta;
    logic               r_sync;
    logic [STATE_W-1:0] r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_level;
    logic               r_rise;
    logic               r_fall;

    logic               w_accept_rise;
    logic               w_accept_fall;

    // With a one-cycle window the first sampled cycle of a new level is accepted
    // straight from the settled state, bypassing the wait state.
    always_comb begin
        w_accept_rise = r_sync &&
                        (((r_state == S_LOW) && c_immediate) ||
                         ((r_state == S_WAIT_HI) && (r_cnt == c_last)));
        w_accept_fall = !r_sync &&
                        (((r_state == S_HIGH) && c_immediate) ||
                         ((r_state == S_WAIT_LO) && (r_cnt == c_last)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_accept_rise) begin
                r_state <= S_HIGH;
                r_cnt   <= '0;
                r_level <= 1'b1;
                r_rise  <= 1'b1;
            end else if (w_accept_fall) begin
                r_state <= S_LOW;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_fall  <= 1'b1;
            end else begin
                case (r_state)
                    S_LOW: begin
                        if (r_sync) begin
                            r_state <= S_WAIT_HI;
                            r_cnt   <= c_one;
                        end
                    end
                    S_WAIT_HI: begin
                        if (!r_sync) begin
                            r_state <= S_LOW;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end
                    S_HIGH: begin
                        if (!r_sync) begin
                            r_state <= S_WAIT_LO;
                            r_cnt   <= c_one;
                        end
                    end
                    S_WAIT_LO: begin
                        if (r_sync) begin
                            r_state <= S_HIGH;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end
                    default: begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

`ifdef SWITCH_DEBOUNCE_CNT_EN
    logic [7:0] r_press_cnt;

    // Counts on the acceptance edge so the count moves together with o_rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_press_cnt <= 8'd0;
        end else if (w_accept_rise) begin
            r_press_cnt <= r_press_cnt + 8'd1;
        end
    end

    assign o_press_cnt = r_press_cnt;
`endif

endmodule

`default_nettype wire

// File: rtl/switch_debounce.sv
// ============================================================================
// Module  : switch_debounce
// Brief   : N_CH independent switch debouncers with rise/fall pulses.
//           Define SWITCH_DEBOUNCE_CNT_EN to add per-channel press counters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int N_CH       = DEFAULT_N_CH,
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int STABLE_CYC = DEFAULT_STABLE_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   raw_in,
    output logic [N_CH-1:0]   level_out,
    output logic [N_CH-1:0]   rise_pulse,
    output logic [N_CH-1:0]   fall_pulse
`ifdef SWITCH_DEBOUNCE_CNT_EN
    ,
    output logic [8*N_CH-1:0] press_cnt
`endif
);

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        debounce_chan #(
            .CNT_W      (CNT_W),
            .STABLE_CYC (STABLE_CYC)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_raw       (raw_in[g]),
            .o_level     (level_out[g]),
            .o_rise      (rise_pulse[g]),
            .o_fall      (fall_pulse[g])
`ifdef SWITCH_DEBOUNCE_CNT_EN
            ,
            .o_press_cnt (press_cnt[8*g +: 8])
`endif
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_switch_debounce.sv
// ============================================================================
// Module  : tb_switch_debounce
// Brief   : Self-checking bench for switch_debounce (STABLE_CYC=8, N_CH=2),
//           directed scenarios plus random toggling against a run-length model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_switch_debounce;

    localparam int N_CH       = 2;
    localparam int STABLE_CYC = 8;
    localparam int LAT        = 2 + STABLE_CYC;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] raw_in = '0;
    logic [N_CH-1:0] level_out;
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;
`ifdef SWITCH_DEBOUNCE_CNT_EN
    logic [8*N_CH-1:0] press_cnt;
`endif

    switch_debounce #(
        .N_CH       (N_CH),
        .CNT_W      (16),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
`ifdef SWITCH_DEBOUNCE_CNT_EN
        ,
        .press_cnt  (press_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the pin level reaches the decision point two edges late;
    // the output flips once the delayed level has disagreed with it for
    // STABLE_CYC consecutive edges.
    logic [N_CH-1:0] m_delay [$];
    int              m_run   [N_CH];
    logic [N_CH-1:0] m_lvl, m_rise, m_fall;
    logic [7:0]      m_press [N_CH];

    task automatic model_reset();
        m_delay = '{'0, '0};
        m_lvl   = '0;
        m_rise  = '0;
        m_fall  = '0;
        for (int c = 0; c < N_CH; c++) begin
            m_run[c]   = 0;
            m_press[c] = 8'd0;
        end
    endtask

    task automatic model_edge();
        logic [N_CH-1:0] seen;
        if (rst) begin
            model_reset();
        end else begin
            seen   = m_delay.pop_front();
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < N_CH; c++) begin
                if (seen[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == STABLE_CYC) begin
                        m_lvl[c] = seen[c];
                        m_run[c] = 0;
                        if (seen[c]) begin
                            m_rise[c]  = 1'b1;
                            m_press[c] = m_press[c] + 8'd1;
                        end else begin
                            m_fall[c] = 1'b1;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_delay.push_back(raw_in);
        end
    endtask

    task automatic check_all(input string tag);
        n_cmp++;
        assert (level_out === m_lvl) else begin
            n_err++;
            $error("FAIL %s level_out got %b exp %b", tag, level_out, m_lvl);
        end
        n_cmp++;
        assert (rise_pulse === m_rise) else begin
            n_err++;
            $error("FAIL %s rise_pulse got %b exp %b", tag, rise_pulse, m_rise);
        end
        n_cmp++;
        assert (fall_pulse === m_fall) else begin
            n_err++;
            $error("FAIL %s fall_pulse got %b exp %b", tag, fall_pulse, m_fall);
        end
`ifdef SWITCH_DEBOUNCE_CNT_EN
        n_cmp++;
        assert (press_cnt === {m_press[1], m_press[0]}) else begin
            n_err++;
            $error("FAIL %s press_cnt got %h exp %h", tag, press_cnt, {m_press[1], m_press[0]});
        end
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic expect_bits(input string tag, input logic [N_CH-1:0] got,
                               input logic [N_CH-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    initial begin
        model_reset();

        // Reset held with both pins high: everything stays cleared.
        rst    = 1'b1;
        raw_in = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick("reset");
            expect_bits("reset_level", level_out, 2'b00);
        end
        raw_in = 2'b00;
        rst    = 1'b0;
        for (int i = 0; i < 4; i++) tick("idle");

        // Clean rise on channel 0: exact latency, single pulse, ch1 untouched.
        raw_in = 2'b01;
        for (int i = 1; i <= LAT; i++) begin
            tick("rise0");
            if (i == LAT - 1) expect_bits("rise0_early", level_out, 2'b00);
        end
        expect_bits("rise0_level", level_out, 2'b01);
        expect_bits("rise0_pulse", rise_pulse, 2'b01);
        expect_bits("rise0_nofall", fall_pulse, 2'b00);
        tick("rise0_after");
        expect_bits("rise0_single", rise_pulse, 2'b00);

        // Back low, then a 5-cycle bounce that must be rejected.
        raw_in = 2'b00;
        for (int i = 0; i < LAT + 2; i++) tick("fall0");
        expect_bits("fall0_level", level_out, 2'b00);
        raw_in = 2'b01;
        for (int i = 0; i < 5; i++) tick("bounce_hi");
        raw_in = 2'b00;
        for (int i = 0; i < LAT + 4; i++) begin
            tick("bounce_lo");
            expect_bits("bounce_level", level_out, 2'b00);
            expect_bits("bounce_rise", rise_pulse, 2'b00);
        end

        // Both channels rise on the same edge.
        raw_in = 2'b11;
        for (int i = 1; i <= 12; i++) begin
            tick("both");
            if (i == LAT) begin
                expect_bits("both_level", level_out, 2'b11);
                expect_bits("both_rise", rise_pulse, 2'b11);
            end
            if (i == LAT + 1) expect_bits("both_single", rise_pulse, 2'b00);
        end
        raw_in = 2'b00;
        for (int i = 0; i < LAT + 2; i++) tick("both_fall");

        // Reset in the middle of a pending rise discards it.
        raw_in = 2'b01;
        for (int i = 0; i < 4; i++) tick("pend");
        rst = 1'b1;
        tick("pend_rst");
        rst = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            tick("pend_after");
            if (i < LAT) expect_bits("pend_wait", level_out, 2'b00);
        end
        expect_bits("pend_level", level_out, 2'b01);
        raw_in = 2'b00;
        for (int i = 0; i < LAT + 2; i++) tick("pend_fall");

`ifdef SWITCH_DEBOUNCE_CNT_EN
        // 257 clean presses on channel 1 wrap its counter to 1.
        rst = 1'b1;
        tick("cnt_rst");
        rst = 1'b0;
        for (int p = 0; p < 257; p++) begin
            raw_in = 2'b10;
            for (int i = 0; i < LAT + 2; i++) tick("cnt_hi");
            raw_in = 2'b00;
            for (int i = 0; i < LAT + 2; i++) tick("cnt_lo");
        end
        n_cmp++;
        assert (press_cnt[15:8] === 8'd1) else begin
            n_err++;
            $error("FAIL cnt_wrap got %0d exp 1", press_cnt[15:8]);
        end
`endif

        // Random toggling with mixed hold lengths and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0)
                raw_in[$urandom_range(0, N_CH - 1)] ^= 1'b1;
            if ($urandom_range(0, 40) == 0)
                raw_in = N_CH'($urandom);
            rst = ($urandom_range(0, 300) == 0);
            tick("random");
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
